// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath defaults and access-width codes.
package mips_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_ADDR_DEF = 5;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    // Byte enables for an aligned access at the given lane.
    function automatic logic [3:0] lane_be(input logic [1:0] width,
                                           input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        unique case (1'b1)
            width[1]:              be = 4'b1111;
            (width == WIDTH_HALF): be = lane[1] ? 4'b1100 : 4'b0011;
            default:               be = 4'b0001 << lane;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage.
// MEM_STAGE_DEBUG_PORT_EN adds the debug word-read port.
interface mem_stage_if #(
    parameter int NB_DATA   = 32,
    parameter int NB_ADDR   = 5,
    parameter int MEM_WORDS = 64
);
    localparam int AW = $clog2(MEM_WORDS);

    logic               i_step;
    logic               i_mem2reg;
    logic               i_memRead;
    logic               i_memWrite;
    logic               i_regWrite;
    logic [1:0]         i_width;
    logic               i_sign_flag;
    logic [NB_ADDR-1:0] i_write_reg;
    logic [NB_DATA-1:0] i_data4Mem;
    logic [NB_DATA-1:0] i_result;
    logic               o_mem2reg;
    logic               o_regWrite;
    logic [NB_ADDR-1:0] o_write_reg;
    logic [NB_DATA-1:0] o_read_data;
    logic [NB_DATA-1:0] o_alu_result;
    logic               o_misaligned;
    logic [NB_DATA-1:0] o_wb_data;
`ifdef MEM_STAGE_DEBUG_PORT_EN
    logic [AW-1:0]      i_dbg_addr;
    logic [NB_DATA-1:0] o_dbg_word;
`endif

    modport master (
`ifdef MEM_STAGE_DEBUG_PORT_EN
        output i_dbg_addr,
        input  o_dbg_word,
`endif
        output i_step, i_mem2reg, i_memRead, i_memWrite, i_regWrite,
        output i_width, i_sign_flag, i_write_reg, i_data4Mem, i_result,
        input  o_mem2reg, o_regWrite, o_write_reg, o_read_data,
        input  o_alu_result, o_misaligned, o_wb_data
    );

    modport slave (
`ifdef MEM_STAGE_DEBUG_PORT_EN
        input  i_dbg_addr,
        output o_dbg_word,
`endif
        input  i_step, i_mem2reg, i_memRead, i_memWrite, i_regWrite,
        input  i_width, i_sign_flag, i_write_reg, i_data4Mem, i_result,
        output o_mem2reg, o_regWrite, o_write_reg, o_read_data,
        output o_alu_result, o_misaligned, o_wb_data
    );

endinterface

// File: rtl/mem_stage_data_memory.sv
// Byte-writable word RAM, synchronous read-before-write port.
// MEM_STAGE_DEBUG_PORT_EN adds an asynchronous debug read port.
module data_memory #(
    parameter int MEM_WORDS = 64,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
`ifdef MEM_STAGE_DEBUG_PORT_EN
    input  logic [AW-1:0] dbg_addr_i,
    output logic [31:0]   dbg_word_o,
`endif
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

`ifdef MEM_STAGE_DEBUG_PORT_EN
    assign dbg_word_o = mem_q[dbg_addr_i];
`endif

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: loads/stores and the MEM/WB register.
// MEM_STAGE_DEBUG_PORT_EN exposes a debug memory read port.
module mem_stage
    import mips_pkg::*;
#(
    parameter int NB_DATA   = NB_DATA_DEF,
    parameter int NB_ADDR   = NB_ADDR_DEF,
    parameter int MEM_WORDS = 64
) (
    input logic        clk,
    input logic        i_reset,
    mem_stage_if.slave bus
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [AW+1:0]      addr;
    logic [1:0]         lane;
    logic               mis;
    logic [3:0]         we;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               mem_en;

    logic               mem2reg_q,  mem2reg_d;
    logic               regwr_q,    regwr_d;
    logic [NB_ADDR-1:0] wreg_q,     wreg_d;
    logic [NB_DATA-1:0] alu_q,      alu_d;
    logic               mis_q,      mis_d;
    logic               rd_ok_q,    rd_ok_d;
    logic [1:0]         width_q,    width_d;
    logic               sign_q,     sign_d;
    logic [1:0]         lane_q,     lane_d;

    logic [31:0]        shifted;
    logic [31:0]        ext;

    assign addr = bus.i_result[AW+1:0];
    assign lane = addr[1:0];

    always_comb begin
        mis = 1'b0;
        if (bus.i_memRead || bus.i_memWrite) begin
            unique case (1'b1)
                bus.i_width[1]:              mis = |lane;
                (bus.i_width == WIDTH_HALF): mis = lane[0];
                default:                     mis = 1'b0;
            endcase
        end
    end

    always_comb begin
        wdata = bus.i_data4Mem[31:0];
        unique case (1'b1)
            bus.i_width[1]:              wdata = bus.i_data4Mem[31:0];
            (bus.i_width == WIDTH_HALF): wdata = {2{bus.i_data4Mem[15:0]}};
            default:                     wdata = {4{bus.i_data4Mem[7:0]}};
        endcase
    end

    // A store seen while reset is held is dropped.
    assign mem_en = bus.i_step && i_reset;
    assign we = (mem_en && bus.i_memWrite && !mis)
              ? lane_be(bus.i_width, lane) : 4'b0000;

    data_memory #(
        .MEM_WORDS (MEM_WORDS)
    ) u_dmem (
        .clk        (clk),
        .en_i       (mem_en),
        .we_i       (we),
        .addr_i     (addr[AW+1:2]),
        .wdata_i    (wdata),
`ifdef MEM_STAGE_DEBUG_PORT_EN
        .dbg_addr_i (bus.i_dbg_addr),
        .dbg_word_o (bus.o_dbg_word),
`endif
        .rdata_o    (rdata)
    );

    assign mem2reg_d = bus.i_mem2reg;
    assign regwr_d   = bus.i_regWrite && !(bus.i_memRead && mis);
    assign wreg_d    = bus.i_write_reg;
    assign alu_d     = bus.i_result;
    assign mis_d     = mis;
    assign rd_ok_d   = bus.i_memRead && !mis;
    assign width_d   = bus.i_width;
    assign sign_d    = bus.i_sign_flag;
    assign lane_d    = lane;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            mem2reg_q <= 1'b0;
            regwr_q   <= 1'b0;
            wreg_q    <= '0;
            alu_q     <= '0;
            mis_q     <= 1'b0;
            rd_ok_q   <= 1'b0;
            width_q   <= 2'b00;
            sign_q    <= 1'b0;
            lane_q    <= 2'b00;
        end else if (bus.i_step) begin
            mem2reg_q <= mem2reg_d;
            regwr_q   <= regwr_d;
            wreg_q    <= wreg_d;
            alu_q     <= alu_d;
            mis_q     <= mis_d;
            rd_ok_q   <= rd_ok_d;
            width_q   <= width_d;
            sign_q    <= sign_d;
            lane_q    <= lane_d;
        end
    end

    // Lane select and extension act on the word captured at the load edge.
    always_comb begin
        shifted = rdata >> {lane_q, 3'b000};
        ext     = rdata;
        unique case (1'b1)
            width_q[1]:
                ext = rdata;
            (width_q == WIDTH_HALF):
                ext = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default:
                ext = {{24{sign_q & shifted[7]}}, shifted[7:0]};
        endcase
    end

    assign bus.o_mem2reg    = mem2reg_q;
    assign bus.o_regWrite   = regwr_q;
    assign bus.o_write_reg  = wreg_q;
    assign bus.o_alu_result = alu_q;
    assign bus.o_misaligned = mis_q;
    assign bus.o_read_data  = rd_ok_q ? NB_DATA'(ext) : '0;
    assign bus.o_wb_data    = mem2reg_q ? bus.o_read_data : alu_q;

endmodule
